// File: rtl/calculator.sv
`default_nettype none
// ============================================================================
// Module   : calculator
// Purpose  : 8-bit, 8-operation registered ALU with a 16-bit result and
//            carry/zero flags. Operations other than divide complete at the
//            accepting clock edge. Divide by a non-zero divisor uses an
//            iterative restoring shift-subtract unit that takes 8 cycles.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            start      - launch strobe (ignored while busy)
//            a, b       - 8-bit unsigned operands
//            opcode     - 3-bit operation select
//            out        - 16-bit registered result
//            carry_flag - carry / borrow / overflow / divide-by-zero flag
//            zero_flag  - set when out is zero
//            busy       - divide in progress
//            done       - one-cycle pulse after out/flags update
// Config   : CALC_DIV_REMAINDER_EN - when defined, DIV returns the remainder
//            in out[15:8]; otherwise out[15:8] is zero for DIV.
// Revision : 1.0 - initial release
// ============================================================================
module calculator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [2:0]  opcode,
    output logic [15:0] out,
    output logic        carry_flag,
    output logic        zero_flag,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_MUL  = 3'b010;
    localparam logic [2:0] c_OP_DIV  = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_SQR  = 3'b101;
    localparam logic [2:0] c_OP_NAND = 3'b110;
    localparam logic [2:0] c_OP_OR   = 3'b111;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_DIV  = 1'b1;

    localparam logic [2:0] c_DIV_LAST = 3'd7;

    // Registered state
    logic [0:0]  r_state;
    logic [15:0] r_out;
    logic        r_carry;
    logic        r_zero;
    logic        r_done;
    logic [7:0]  r_rem;   // partial remainder
    logic [7:0]  r_quo;   // dividend bits shift out MSB-first, quotient bits shift in
    logic [7:0]  r_dvs;   // captured divisor
    logic [2:0]  r_cnt;   // divide iteration counter

    // Single-cycle datapath
    logic [8:0]  w_sum;
    logic [8:0]  w_diff;
    logic [15:0] w_prod;
    logic [15:0] w_sqr;
    logic [15:0] w_result;
    logic        w_carry;
    logic        w_div_launch;

    // Divider step
    logic [8:0]  w_rem_shift;
    logic        w_ge;
    logic [7:0]  w_rem_sub;
    logic [7:0]  w_rem_next;
    logic [7:0]  w_quo_next;
    logic [15:0] w_div_out;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};   // bit 8 is the borrow
    assign w_prod = {8'h00, a} * {8'h00, b};
    assign w_sqr  = {8'h00, a} * {8'h00, a};

    assign w_div_launch = (opcode == c_OP_DIV) && (b != 8'h00);

    always_comb begin
        w_result = 16'h0000;
        w_carry  = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                w_result = {7'b0, w_sum};
                w_carry  = w_sum[8];
            end
            c_OP_SUB: begin
                w_result = {8'h00, w_diff[7:0]};
                w_carry  = w_diff[8];
            end
            c_OP_MUL: begin
                w_result = w_prod;
                w_carry  = |w_prod[15:8];
            end
            c_OP_DIV: begin
                // Only reaches this path for a zero divisor; non-zero
                // divisors go through the iterative unit.
                w_result = 16'hFFFF;
                w_carry  = 1'b1;
            end
            c_OP_XOR:  w_result = {8'h00, a ^ b};
            c_OP_SQR: begin
                w_result = w_sqr;
                w_carry  = |w_sqr[15:8];
            end
            c_OP_NAND: w_result = {8'h00, ~(a & b)};
            c_OP_OR:   w_result = {8'h00, a | b};
            default: begin
                w_result = 16'h0000;
                w_carry  = 1'b0;
            end
        endcase
    end

    // Restoring division step: bring down the next dividend bit and subtract
    // the divisor when it fits. The remainder is always below the divisor, so
    // an 8-bit modular subtraction yields the exact new remainder.
    assign w_rem_shift = {r_rem, r_quo[7]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_dvs});
    assign w_rem_sub   = w_rem_shift[7:0] - r_dvs;
    assign w_rem_next  = w_ge ? w_rem_sub : w_rem_shift[7:0];
    assign w_quo_next  = {r_quo[6:0], w_ge};

`ifdef CALC_DIV_REMAINDER_EN
    assign w_div_out = {w_rem_next, w_quo_next};
`else
    assign w_div_out = {8'h00, w_quo_next};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_out   <= 16'h0000;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
            r_rem   <= 8'h00;
            r_quo   <= 8'h00;
            r_dvs   <= 8'h00;
            r_cnt   <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (w_div_launch) begin
                            r_state <= c_ST_DIV;
                            r_rem   <= 8'h00;
                            r_quo   <= a;
                            r_dvs   <= b;
                            r_cnt   <= 3'd0;
                        end else begin
                            r_out   <= w_result;
                            r_carry <= w_carry;
                            r_zero  <= (w_result == 16'h0000);
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_ST_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == c_DIV_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_out   <= w_div_out;
                        r_carry <= 1'b0;
                        r_zero  <= (w_div_out == 16'h0000);
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign out        = r_out;
    assign carry_flag = r_carry;
    assign zero_flag  = r_zero;
    assign busy       = (r_state == c_ST_DIV);
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_calculator.sv
`default_nettype none
// ============================================================================
// Module   : tb_calculator
// Purpose  : Directed self-checking bench for calculator. Expected values
//            are hand-computed constants. Honours CALC_DIV_REMAINDER_EN for
//            the divide result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calculator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  opcode;
    logic [15:0] out;
    logic        carry_flag;
    logic        zero_flag;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    calculator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .out        (out),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one start strobe; returns at the negedge after the accepting edge.
    task automatic launch(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        opcode = op;
        a      = x;
        b      = y;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [15:0] e_out,
                             input logic e_carry, input logic e_zero);
        check({tag, ".out"},   out,                 e_out);
        check({tag, ".carry"}, {15'b0, carry_flag}, {15'b0, e_carry});
        check({tag, ".zero"},  {15'b0, zero_flag},  {15'b0, e_zero});
        check({tag, ".done"},  {15'b0, done},       16'h0001);
        check({tag, ".busy"},  {15'b0, busy},       16'h0000);
    endtask

    logic [7:0]  t1_a   [4];
    logic [7:0]  t1_b   [4];
    logic [15:0] t1_exp [4];
    logic [15:0] div_exp;
    int          cyc;
    int          n_done;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        opcode   = 3'b000;
`ifdef CALC_DIV_REMAINDER_EN
        div_exp = 16'h041C;
`else
        div_exp = 16'h001C;
`endif

        // Reset state
        #2;
        check("rst.out",   out,                 16'h0000);
        check("rst.carry", {15'b0, carry_flag}, 16'h0000);
        check("rst.zero",  {15'b0, zero_flag},  16'h0000);
        check("rst.busy",  {15'b0, busy},       16'h0000);
        check("rst.done",  {15'b0, done},       16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: small ADDs, 10-cycle spacing, single done pulse each
        t1_a = '{8'd1, 8'd3, 8'd1, 8'd3};
        t1_b = '{8'd1, 8'd1, 8'd3, 8'd3};
        t1_exp = '{16'd2, 16'd4, 16'd4, 16'd6};
        for (int i = 0; i < 4; i++) begin
            launch(3'b000, t1_a[i], t1_b[i]);
            check_res($sformatf("add%0d", i), t1_exp[i], 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("add%0d.done_low", i), {15'b0, done}, 16'h0000);
            check($sformatf("add%0d.hold", i), out, t1_exp[i]);
            repeat (7) @(negedge clk);
        end

        // 2: carry, zero, borrow
        launch(3'b000, 8'hFF, 8'h01);
        check_res("add_ovf", 16'h0100, 1'b1, 1'b0);
        launch(3'b001, 8'd3, 8'd3);
        check_res("sub_zero", 16'h0000, 1'b0, 1'b1);
        launch(3'b001, 8'd1, 8'd3);
        check_res("sub_borrow", 16'h00FE, 1'b1, 1'b0);

        // 3: multiply and square
        launch(3'b010, 8'hFF, 8'hFF);
        check_res("mul", 16'hFE01, 1'b1, 1'b0);
        launch(3'b101, 8'h0F, 8'hAA);
        check_res("sqr", 16'h00E1, 1'b0, 1'b0);

        // Back-to-back non-DIV starts
        @(negedge clk);
        opcode = 3'b000; a = 8'd1; b = 8'd1; start = 1'b1;
        @(negedge clk);
        check_res("b2b0", 16'd2, 1'b0, 1'b0);
        a = 8'd3; b = 8'd3;
        @(negedge clk);
        check_res("b2b1", 16'd6, 1'b0, 1'b0);
        start = 1'b0;
        @(negedge clk);
        check("b2b.done_low", {15'b0, done}, 16'h0000);

        // 4: DIV 200/7, with an ignored start while busy and changed inputs
        launch(3'b011, 8'd200, 8'd7);
        check("div.busy", {15'b0, busy}, 16'h0001);
        check("div.done_early", {15'b0, done}, 16'h0000);
        check("div.out_hold", out, 16'd6);
        opcode = 3'b000; a = 8'h55; b = 8'h01; start = 1'b1;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        check("div.latency", cyc[15:0], 16'd8);
        check_res("div", div_exp, 1'b0, 1'b0);
        @(negedge clk);
        check("div.done_low", {15'b0, done}, 16'h0000);
        check("div.no_queue", out, div_exp);
        check("div.busy_low", {15'b0, busy}, 16'h0000);

        // 5: divide by zero
        launch(3'b011, 8'd5, 8'd0);
        check_res("div0", 16'hFFFF, 1'b1, 1'b0);

        // 6: logic operations
        launch(3'b100, 8'hF0, 8'h3C);
        check_res("xor", 16'h00CC, 1'b0, 1'b0);
        launch(3'b110, 8'hF0, 8'h3C);
        check_res("nand", 16'h00CF, 1'b0, 1'b0);
        launch(3'b111, 8'hF0, 8'h3C);
        check_res("or", 16'h00FC, 1'b0, 1'b0);

        // Reset mid-divide aborts with no done afterwards
        launch(3'b011, 8'd200, 8'd7);
        repeat (3) @(negedge clk);
        check("abort.busy_before", {15'b0, busy}, 16'h0001);
        rst_n = 1'b0;
        #1;
        check("abort.out",   out,                 16'h0000);
        check("abort.carry", {15'b0, carry_flag}, 16'h0000);
        check("abort.zero",  {15'b0, zero_flag},  16'h0000);
        check("abort.busy",  {15'b0, busy},       16'h0000);
        check("abort.done",  {15'b0, done},       16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort.no_done", n_done[15:0], 16'd0);
        check("abort.idle", {15'b0, busy}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
